// File: rtl/ro_pair_freq_comparator.sv
// RO-pair frequency comparator: counts rising edges of two ring oscillators
// over a fixed clock window and derives one PUF response bit plus reliability.
module ro_pair_freq_comparator #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 20,
  parameter int WINDOW     = 50000,
  parameter int SETTLE_CYC = 4,
  parameter int MARGIN     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic             resp_bit,
  output logic             reliable,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COUNT,
    DONE
  } state_t;

  localparam logic [WIN_W-1:0] SET_LAST = WIN_W'(SETTLE_CYC - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW);
  localparam logic [CNT_W-1:0] CMAX     = '1;
  localparam logic [CNT_W:0]   MARG     = (CNT_W+1)'(MARGIN);

  state_t           state;
  state_t           nxt;
  logic [WIN_W-1:0] tmr;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [2:0]       sa;
  logic [2:0]       sb;
  logic             edge_a;
  logic             edge_b;
  logic             clr;
  logic             tmr_clr;
  logic             cnt_en;
  logic             ld;
  logic [CNT_W:0]   diff;
  logic [CNT_W:0]   mag;

  // Two-flop synchronizers plus a third flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
    end else begin
      sa <= {sa[1:0], ro_a};
      sb <= {sb[1:0], ro_b};
    end
  end

  assign edge_a = sa[1] & ~sa[2];
  assign edge_b = sb[1] & ~sb[2];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state and control decode; COUNT ends with one closing cycle
  // (no counting) in which the final counts are latched into the results
  always_comb begin
    nxt     = state;
    ro_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    clr     = 1'b0;
    tmr_clr = 1'b0;
    cnt_en  = 1'b0;
    ld      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          nxt = SETTLE;
          clr = 1'b1;
        end
      end
      SETTLE: begin
        ro_en = 1'b1;
        busy  = 1'b1;
        if (tmr == SET_LAST) begin
          nxt     = COUNT;
          tmr_clr = 1'b1;
        end
      end
      COUNT: begin
        ro_en  = 1'b1;
        busy   = 1'b1;
        cnt_en = (tmr != WIN_LAST);
        if (tmr == WIN_LAST) begin
          nxt = DONE;
          ld  = 1'b1;
        end
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Shared phase timer for settle and count windows
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 tmr <= '0;
    else if (clr || tmr_clr) tmr <= '0;
    else if (state != IDLE)  tmr <= tmr + WIN_W'(1);
  end

  // Saturating edge counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (cnt_en) begin
      if (edge_a && cnt_a != CMAX) cnt_a <= cnt_a + CNT_W'(1);
      if (edge_b && cnt_b != CMAX) cnt_b <= cnt_b + CNT_W'(1);
    end
  end

  assign diff = {1'b0, cnt_a} - {1'b0, cnt_b};
  assign mag  = diff[CNT_W] ? -diff : diff;

  // Result registers, updated only as DONE is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_a  <= '0;
      count_b  <= '0;
      resp_bit <= 1'b0;
      reliable <= 1'b0;
    end else if (ld) begin
      count_a  <= cnt_a;
      count_b  <= cnt_b;
      resp_bit <= (cnt_a > cnt_b);
      reliable <= (mag >= MARG);
    end
  end

endmodule

// File: tb/tb_ro_pair_freq_comparator.sv
// Directed bench for ro_pair_freq_comparator: window 1000, settle 4,
// plus a 6-bit counter instance for saturation.
`timescale 1ns/100ps
module tb_ro_pair_freq_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ro_a = 1'b0;
  logic        ro_b = 1'b0;
  logic        sro_a = 1'b0;
  logic        sro_b = 1'b0;
  logic        ro_en, busy, done, resp_bit, reliable;
  logic [15:0] count_a, count_b;
  logic        s_ro_en, s_busy, s_done, s_resp, s_rel;
  logic [5:0]  s_cnt_a, s_cnt_b;

  realtime ha_a = 40.0;
  realtime ha_b = 50.0;
  realtime hs_a = 20.0;
  realtime hs_b = 320.0;

  int vecs = 0;
  int errs = 0;
  int n, n2, dn, bz;

  ro_pair_freq_comparator #(
    .CNT_W(16), .WIN_W(20), .WINDOW(1000), .SETTLE_CYC(4), .MARGIN(8)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .busy(busy), .done(done), .resp_bit(resp_bit),
    .reliable(reliable), .count_a(count_a), .count_b(count_b)
  );

  ro_pair_freq_comparator #(
    .CNT_W(6), .WIN_W(20), .WINDOW(1000), .SETTLE_CYC(4), .MARGIN(8)
  ) u_sat (
    .clk(clk), .rst(rst), .start(start), .ro_a(sro_a), .ro_b(sro_b),
    .ro_en(s_ro_en), .busy(s_busy), .done(s_done), .resp_bit(s_resp),
    .reliable(s_rel), .count_a(s_cnt_a), .count_b(s_cnt_b)
  );

  always #5 clk = ~clk;

  initial begin #1.3; forever #(ha_a) ro_a = ~ro_a; end
  initial begin #1.3; forever #(ha_b) ro_b = ~ro_b; end
  initial begin #1.3; forever #(hs_a) sro_a = ~sro_a; end
  initial begin #1.3; forever #(hs_b) sro_b = ~sro_b; end

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs,
                         input int lo, input int hi);
    vecs++;
    assert (obs >= lo && obs <= hi) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic launch(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_start", int'(busy), 1);
    chk("ro_en_settle", int'(ro_en), 1);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!done && cyc < 2000);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ro_en", int'(ro_en), 0);
    chk("rst_count_a", int'(count_a), 0);
    chk("rst_resp", int'(resp_bit), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // a faster than b; 6-bit instance saturates in parallel
    launch(1'b0);
    wait_done(n);
    chk("t1_latency", n, 1005);
    chk("t1_done", int'(done), 1);
    chk("t1_ro_en_done", int'(ro_en), 0);
    chk_rng("t1_count_a", int'(count_a), 124, 126);
    chk_rng("t1_count_b", int'(count_b), 99, 101);
    chk("t1_resp", int'(resp_bit), 1);
    chk("t1_rel", int'(reliable), 1);
    chk("t4_done", int'(s_done), 1);
    chk("t4_sat_a", int'(s_cnt_a), 63);
    chk_rng("t4_count_b", int'(s_cnt_b), 15, 16);
    chk("t4_resp", int'(s_resp), 1);
    @(posedge clk);
    #1;
    chk("t1_done_pulse", int'(done), 0);
    chk("t1_idle_busy", int'(busy), 0);
    chk_rng("t1_hold_a", int'(count_a), 124, 126);

    // b faster than a
    ha_a = 50.0;
    ha_b = 40.0;
    repeat (5) @(posedge clk);
    launch(1'b0);
    chk_rng("t2_hold_a", int'(count_a), 124, 126);
    wait_done(n);
    chk("t2_latency", n, 1005);
    chk_rng("t2_count_a", int'(count_a), 99, 101);
    chk_rng("t2_count_b", int'(count_b), 124, 126);
    chk("t2_resp", int'(resp_bit), 0);
    chk("t2_rel", int'(reliable), 1);

    // close frequencies, difference under the margin
    ha_a = 50.0;
    ha_b = 52.0;
    repeat (5) @(posedge clk);
    launch(1'b0);
    wait_done(n);
    chk_rng("t3_count_a", int'(count_a), 99, 101);
    chk_rng("t3_count_b", int'(count_b), 95, 98);
    chk("t3_resp", int'(resp_bit), 1);
    chk("t3_rel", int'(reliable), 0);

    // start pulsed during busy is ignored
    ha_a = 40.0;
    ha_b = 50.0;
    repeat (5) @(posedge clk);
    launch(1'b0);
    repeat (200) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("t6_pulse_latency", 201 + n, 1005);
    bz = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy) bz++;
    end
    chk("t6_no_requeue", bz, 0);

    // start held high: back-to-back runs
    launch(1'b1);
    wait_done(n);
    chk("t6_first_latency", n, 1005);
    chk("t6_ro_en_done", int'(ro_en), 0);
    @(posedge clk);
    #1;
    chk("t6_ro_en_idle", int'(ro_en), 0);
    chk("t6_busy_idle", int'(busy), 0);
    @(posedge clk);
    #1;
    chk("t6_ro_en_settle", int'(ro_en), 1);
    wait_done(n2);
    chk("t6_spacing", 2 + n2, 1007);
    chk_rng("t6_count_a", int'(count_a), 124, 126);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_stop_busy", int'(busy), 0);

    // reset mid-COUNT aborts the run
    launch(1'b0);
    repeat (500) @(posedge clk);
    #1;
    chk("t5_busy_mid", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_ro_en", int'(ro_en), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_count_a", int'(count_a), 0);
    chk("t5_count_b", int'(count_b), 0);
    chk("t5_resp", int'(resp_bit), 0);
    chk("t5_rel", int'(reliable), 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (600) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    chk("t5_no_done", dn, 0);
    launch(1'b0);
    wait_done(n);
    chk("t5_rerun_latency", n, 1005);
    chk_rng("t5_rerun_a", int'(count_a), 124, 126);
    chk_rng("t5_rerun_b", int'(count_b), 99, 101);
    chk("t5_rerun_resp", int'(resp_bit), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
